// File: rtl/my_regfile.sv
// my_regfile: 32 x 32-bit register file with two combinational read ports and one write port.
// Register r0 has no storage and always reads as zero.
//
// Ports:
//   clock             - single clock; all state changes on its rising edge
//   ctrl_reset        - synchronous, active-high reset; clears r1..r31 and wins over a write
//   ctrl_writeEnable  - write strobe
//   ctrl_writeReg     - write address (writes to 0 are dropped)
//   ctrl_readRegA/B   - read addresses for ports A and B
//   data_writeReg     - write data
//   data_readRegA/B   - combinational read data (no write-to-read bypass)
module my_regfile (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ctrl_writeEnable,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  input  logic [31:0] data_writeReg,
  output logic [31:0] data_readRegA,
  output logic [31:0] data_readRegB
);

  // Storage exists only for r1..r31.
  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];

  // Read view including the hard-wired zero at index 0.
  logic [31:0] rd_vec [32];

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      if (ctrl_reset) begin
        regs_d[i] = '0;
      end else if (ctrl_writeEnable && (ctrl_writeReg == 5'(i))) begin
        // i never equals 0 here, so writes to r0 fall through untouched.
        regs_d[i] = data_writeReg;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 1; i < 32; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rd_vec[0] = '0;
    for (int i = 1; i < 32; i++) begin
      rd_vec[i] = regs_q[i];
    end
  end

  // Reads come straight from the stored state, so a same-cycle write is seen only after the edge.
  assign data_readRegA = rd_vec[ctrl_readRegA];
  assign data_readRegB = rd_vec[ctrl_readRegB];

endmodule

// File: tb/tb_my_regfile.sv
// Self-checking bench for my_regfile: directed scenarios plus randomized traffic against an
// array-based reference model.
module tb_my_regfile;

  logic        clock;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_writeReg;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  my_regfile dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: plain array of register contents.
  logic [31:0] mem [32];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mem[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one rising edge and apply the architectural effect of the inputs to the model.
  task automatic tick();
    @(posedge clock);
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end else if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
      mem[ctrl_writeReg] = data_writeReg;
    end
    #1;
  endtask

  task automatic idle();
    ctrl_reset       = 1'b0;
    ctrl_writeEnable = 1'b0;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    ctrl_reset       = 1'b0;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = a;
    data_writeReg    = d;
    tick();
    ctrl_writeEnable = 1'b0;
  endtask

  task automatic sweep(input string tag);
    idle();
    for (int a = 0; a < 32; a++) begin
      ctrl_readRegA = 5'(a);
      ctrl_readRegB = 5'(31 - a);
      #1;
      check({tag, "_a"}, data_readRegA, model_rd(5'(a)));
      check({tag, "_b"}, data_readRegB, model_rd(5'(31 - a)));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    ctrl_readRegA    = 5'd0;
    ctrl_readRegB    = 5'd0;
    data_writeReg    = 32'h0;

    // Reset for one edge, then every address reads zero.
    tick();
    sweep("reset_sweep");

    // Fill r1..r31 on consecutive edges.
    ctrl_writeEnable = 1'b1;
    for (int i = 1; i < 32; i++) begin
      ctrl_writeReg = 5'(i);
      data_writeReg = 32'(i * 1000 + 7);
      tick();
    end
    sweep("write_all");
    check("r5_fill", mem[5], 32'd5007);

    // r0 ignores writes.
    write(5'd0, 32'hDEADBEEF);
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;
    #1;
    check("r0_a", data_readRegA, 32'h0);
    check("r0_b", data_readRegB, 32'h0);

    // Disabled write leaves r5 alone.
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd5;
    data_writeReg    = 32'h12345678;
    tick();
    ctrl_readRegA = 5'd5;
    #1;
    check("we_guard", data_readRegA, 32'd5007);

    // Same-cycle read/write of r7: old value before the edge, new after.
    write(5'd7, 32'd5);
    ctrl_readRegA    = 5'd7;
    ctrl_readRegB    = 5'd6;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd7;
    data_writeReg    = 32'd9;
    #1;
    check("rw_before", data_readRegA, 32'd5);
    check("rw_other_before", data_readRegB, 32'd6007);
    tick();
    check("rw_after", data_readRegA, 32'd9);
    check("rw_other_after", data_readRegB, 32'd6007);
    sweep("rw_sweep");

    // Reset beats a simultaneous write; the next edge writes normally.
    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd3;
    data_writeReg    = 32'hFFFFFFFF;
    tick();
    ctrl_reset    = 1'b0;
    data_writeReg = 32'h80000000;
    ctrl_readRegA = 5'd3;
    ctrl_readRegB = 5'd3;
    #1;
    check("rst_prio_a", data_readRegA, 32'h0);
    check("rst_prio_b", data_readRegB, 32'h0);
    tick();
    check("post_rst_a", data_readRegA, 32'h80000000);
    check("post_rst_b", data_readRegB, 32'h80000000);
    ctrl_writeEnable = 1'b0;

    // Mid-run reset clears loaded registers.
    write(5'd10, 32'd42);
    write(5'd31, 32'hFFFFFFFF);
    ctrl_readRegA = 5'd10;
    ctrl_readRegB = 5'd31;
    #1;
    check("mid_load_a", data_readRegA, 32'd42);
    check("mid_load_b", data_readRegB, 32'hFFFFFFFF);
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    check("mid_rst_a", data_readRegA, 32'h0);
    check("mid_rst_b", data_readRegB, 32'h0);

    // Randomized traffic, checked before and after every edge.
    for (int n = 0; n < 500; n++) begin
      ctrl_reset       = ($urandom_range(0, 39) == 0);
      ctrl_writeEnable = ($urandom_range(0, 3) != 0);
      ctrl_writeReg    = 5'($urandom);
      case ($urandom_range(0, 5))
        0:       data_writeReg = 32'hFFFFFFFF;
        1:       data_writeReg = 32'h80000000;
        default: data_writeReg = $urandom;
      endcase
      ctrl_readRegA = ($urandom_range(0, 3) == 0) ? ctrl_writeReg : 5'($urandom);
      ctrl_readRegB = 5'($urandom);
      #1;
      check("rnd_pre_a", data_readRegA, model_rd(ctrl_readRegA));
      check("rnd_pre_b", data_readRegB, model_rd(ctrl_readRegB));
      tick();
      check("rnd_post_a", data_readRegA, model_rd(ctrl_readRegA));
      check("rnd_post_b", data_readRegB, model_rd(ctrl_readRegB));
    end
    sweep("final_sweep");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
